// File: rtl/cim_seq_ctrl_pkg.sv
// Shared state, opcode and sizing definitions for the CIM macro sequencer.
package cim_seq_ctrl_pkg;

   typedef enum logic [2:0] {StIdle, StWload, StAlign, StRun, StDone} state_e;

   typedef enum logic {OpWload = 1'b0, OpCompute = 1'b1} op_e;

   localparam int unsigned N12           = 12;
   localparam int unsigned N24           = 24;
   localparam int unsigned ALIGN_TIMEOUT = 32;
   localparam int unsigned ROWS          = 8;

   // Terminal phase index of RUN for the selected input width.
   function automatic logic [4:0] run_last_phase(input logic wide);
      return wide ? 5'(N24 - 1) : 5'(N12 - 1);
   endfunction

endpackage

// File: rtl/cim_seq_ctrl_if.sv
// Host-side command, weight-data and result handshakes of the CIM sequencer.
interface cim_seq_ctrl_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic        cmd_bank;
   logic        cmd_inwidth;
   logic        wdata_valid;
   logic        wdata_ready;
   logic [23:0] wdata;
   logic        res_valid;
   logic        res_ready;
   logic [50:0] res_data;

   modport master (
      output cmd_valid, cmd_op, cmd_bank, cmd_inwidth, wdata_valid, wdata, res_ready,
      input  cmd_ready, wdata_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_bank, cmd_inwidth, wdata_valid, wdata, res_ready,
      output cmd_ready, wdata_ready, res_valid, res_data
   );

endinterface

// File: rtl/cim_phase_cnt.sv
// 5-bit loadable up-counter with a terminal-count compare, shared by RUN and ALIGN.
module cim_phase_cnt (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [4:0] load_val_i,
   input  logic       en_i,
   input  logic [4:0] tc_val_i,
   output logic       tc_o
);

   logic [4:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/cim_seq_ctrl.sv
// Sequencer for a CIM macro: loads weight rows, aligns to the frame strobe,
// runs N accumulate phases and hands the captured result back to the host.
module cim_seq_ctrl
   import cim_seq_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   cim_seq_ctrl_if.slave bus,
   output logic [23:0]   D,
   output logic [7:0]    WA,
   output logic          cima,
   output logic          inwidth,
   output logic          acm_en,
   input  logic          st,
   input  logic [50:0]   nout,
   output logic          busy,
   output logic          err,
   output logic [15:0]   done_cnt
);

   state_e      state_q, state_d;
   logic [2:0]  row_q, row_d;
   logic [7:0]  wa_q, wa_d;
   logic [23:0] wd_q, wd_d;
   logic        cima_q, cima_d;
   logic        inwidth_q, inwidth_d;
   logic        acm_en_q, acm_en_d;
   logic        wdata_ready_q, wdata_ready_d;
   logic        res_valid_q, res_valid_d;
   logic [50:0] res_data_q, res_data_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [15:0] done_cnt_q, done_cnt_d;

   logic       cnt_load, cnt_en, cnt_tc;
   logic [4:0] cnt_tc_val;

   cim_phase_cnt u_phase_cnt (
      .clk_i      (clk),
      .rst_ni     (rstn),
      .load_i     (cnt_load),
      .load_val_i (5'd0),
      .en_i       (cnt_en),
      .tc_val_i   (cnt_tc_val),
      .tc_o       (cnt_tc)
   );

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      wa_d        = '0;
      wd_d        = wd_q;
      cima_d      = cima_q;
      inwidth_d   = inwidth_q;
      acm_en_d    = acm_en_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      err_d       = err_q;
      done_cnt_d  = done_cnt_q;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
      // One counter serves both phases; only the terminal value differs.
      cnt_tc_val  = (state_q == StRun) ? run_last_phase(inwidth_q) : 5'(ALIGN_TIMEOUT - 1);

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               cima_d    = bus.cmd_bank;
               inwidth_d = bus.cmd_inwidth;
               cnt_load  = 1'b1;
               if (op_e'(bus.cmd_op) == OpCompute) begin
                  state_d  = StAlign;
                  acm_en_d = 1'b0;
               end else begin
                  state_d = StWload;
                  row_d   = '0;
               end
            end
         end
         StWload: begin
            if (bus.wdata_valid && wdata_ready_q) begin
               wa_d  = 8'd1 << row_q;
               wd_d  = bus.wdata;
               row_d = row_q + 3'd1;
               if (row_q == 3'(ROWS - 1)) begin
                  state_d = StIdle;
               end
            end
         end
         StAlign: begin
            if (st) begin
               state_d  = StRun;
               acm_en_d = 1'b1;
               cnt_load = 1'b1;
            end else if (cnt_tc) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         StRun: begin
            if (cnt_tc) begin
               state_d     = StDone;
               acm_en_d    = 1'b0;
               res_valid_d = 1'b1;
               res_data_d  = nout;
               done_cnt_d  = done_cnt_q + 16'd1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         StDone: begin
            if (bus.res_ready) begin
               state_d     = StIdle;
               res_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      wdata_ready_d = (state_d == StWload);
      busy_d        = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= StIdle;
         row_q         <= '0;
         wa_q          <= '0;
         wd_q          <= '0;
         cima_q        <= 1'b0;
         inwidth_q     <= 1'b0;
         acm_en_q      <= 1'b0;
         wdata_ready_q <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         done_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         wa_q          <= wa_d;
         wd_q          <= wd_d;
         cima_q        <= cima_d;
         inwidth_q     <= inwidth_d;
         acm_en_q      <= acm_en_d;
         wdata_ready_q <= wdata_ready_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
         done_cnt_q    <= done_cnt_d;
      end
   end

   assign bus.cmd_ready   = (state_q == StIdle);
   assign bus.wdata_ready = wdata_ready_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign D               = wd_q;
   assign WA              = wa_q;
   assign cima            = cima_q;
   assign inwidth         = inwidth_q;
   assign acm_en          = acm_en_q;
   assign busy            = busy_q;
   assign err             = err_q;
   assign done_cnt        = done_cnt_q;

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Randomized bench for cim_seq_ctrl, checked against a transaction-level model
// of row order, phase counts, latency, result capture and the status counters.
module tb_cim_seq_ctrl;

   logic        clk;
   logic        rstn;
   logic        st;
   logic [50:0] nout;
   logic [23:0] D;
   logic [7:0]  WA;
   logic        cima;
   logic        inwidth;
   logic        acm_en;
   logic        busy;
   logic        err;
   logic [15:0] done_cnt;

   cim_seq_ctrl_if bus ();

   cim_seq_ctrl dut (
      .clk      (clk),
      .rstn     (rstn),
      .bus      (bus),
      .D        (D),
      .WA       (WA),
      .cima     (cima),
      .inwidth  (inwidth),
      .acm_en   (acm_en),
      .st       (st),
      .nout     (nout),
      .busy     (busy),
      .err      (err),
      .done_cnt (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   // Model of the sticky/latched state visible on the outputs.
   logic        exp_cima;
   logic        exp_inwidth;
   logic        exp_err;
   logic [15:0] exp_done;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_wload(input logic bank, input int gap, input bit rand_gap, input bit ramp);
      logic [23:0] data;
      int          beats;
      int          cyc;
      int          wait_n;
      int          stray;
      bit          offer;
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = 1'b0;
      bus.cmd_bank    = bank;
      bus.cmd_inwidth = 1'($urandom_range(0, 1));
      exp_cima        = bank;
      exp_inwidth     = bus.cmd_inwidth;
      tick();
      bus.cmd_valid = 1'b0;
      check_eq("wl_cima", 64'(cima), 64'(exp_cima));
      check_eq("wl_inwidth", 64'(inwidth), 64'(exp_inwidth));
      check_eq("wl_wready", 64'(bus.wdata_ready), 64'(1));
      check_eq("wl_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      beats  = 0;
      wait_n = 0;
      stray  = 0;
      for (cyc = 0; cyc < 200 && beats < 8; cyc++) begin
         offer           = rand_gap ? 1'($urandom_range(0, 1)) : (wait_n == 0);
         data            = ramp ? 24'(beats + 1) : 24'($urandom);
         bus.wdata_valid = offer;
         bus.wdata       = data;
         tick();
         if (offer) begin
            check_eq("wl_wa", 64'(WA), 64'(8'd1 << beats));
            check_eq("wl_d", 64'(D), 64'(data));
            beats++;
            wait_n = gap;
         end else begin
            if (WA !== 8'd0) stray++;
            if (wait_n > 0) wait_n--;
         end
      end
      check_eq("wl_beats", 64'(beats), 64'(8));
      check_eq("wl_gap_wa", 64'(stray), 64'(0));
      // A ninth beat offered right after the last row must not be taken.
      bus.wdata_valid = 1'b1;
      bus.wdata       = 24'($urandom);
      tick();
      check_eq("wl_no9th_wa", 64'(WA), 64'(0));
      check_eq("wl_end_ready", 64'(bus.cmd_ready), 64'(1));
      check_eq("wl_end_wready", 64'(bus.wdata_ready), 64'(0));
      check_eq("wl_end_busy", 64'(busy), 64'(0));
      bus.wdata_valid = 1'b0;
   endtask

   // st_at < 0 means the frame strobe never arrives.
   task automatic do_compute(input logic wide, input logic bank, input int st_at,
                             input int hold, input bit fixed_nout);
      int          n;
      int          cyc;
      int          acm_cnt;
      int          got_lat;
      int          busy_cnt;
      int          stray;
      bit          rv_seen;
      logic [50:0] held;
      n               = wide ? 24 : 12;
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = 1'b1;
      bus.cmd_bank    = bank;
      bus.cmd_inwidth = wide;
      exp_cima        = bank;
      exp_inwidth     = wide;
      tick();
      bus.cmd_valid = 1'b0;
      check_eq("cp_cima", 64'(cima), 64'(exp_cima));
      check_eq("cp_inwidth", 64'(inwidth), 64'(exp_inwidth));
      check_eq("cp_acm_start", 64'(acm_en), 64'(0));
      check_eq("cp_busy", 64'(busy), 64'(1));
      check_eq("cp_err_pre", 64'(err), 64'(exp_err));
      stray = 0;
      if (st_at < 0) begin
         busy_cnt = 0;
         rv_seen  = 1'b0;
         for (int k = 0; k < 32; k++) begin
            st              = 1'b0;
            bus.wdata_valid = 1'($urandom_range(0, 1));
            tick();
            if (busy) busy_cnt++;
            if (bus.res_valid) rv_seen = 1'b1;
            if (WA !== 8'd0 || bus.wdata_ready !== 1'b0) stray++;
         end
         exp_err = 1'b1;
         check_eq("to_busy_cycles", 64'(busy_cnt), 64'(31));
         check_eq("to_err", 64'(err), 64'(1));
         check_eq("to_cmd_ready", 64'(bus.cmd_ready), 64'(1));
         check_eq("to_res_valid", 64'(rv_seen), 64'(0));
         check_eq("to_acm_en", 64'(acm_en), 64'(0));
      end else begin
         acm_cnt = 0;
         got_lat = -1;
         for (cyc = 0; cyc < 80 && got_lat < 0; cyc++) begin
            // Strobe noise after the aligning strobe must not disturb RUN.
            st = (cyc == st_at) ? 1'b1 : ((cyc > st_at) ? 1'($urandom_range(0, 1)) : 1'b0);
            nout            = fixed_nout ? 51'h123 : 51'({$urandom, $urandom});
            bus.wdata_valid = 1'($urandom_range(0, 1));
            tick();
            if (acm_en) acm_cnt++;
            if (WA !== 8'd0 || bus.wdata_ready !== 1'b0) stray++;
            if (bus.res_valid) got_lat = cyc + 1;
         end
         st       = 1'b0;
         exp_done = exp_done + 16'd1;
         // ALIGN spans st_at+1 cycles including the strobe cycle, then N RUN cycles.
         check_eq("cp_latency", 64'(got_lat), 64'(st_at + 1 + n));
         check_eq("cp_acm_cycles", 64'(acm_cnt), 64'(n));
         check_eq("cp_res_data", 64'(bus.res_data), 64'(nout));
         check_eq("cp_done_cnt", 64'(done_cnt), 64'(exp_done));
         check_eq("cp_acm_end", 64'(acm_en), 64'(0));
         check_eq("cp_err", 64'(err), 64'(exp_err));
         held = bus.res_data;
         for (int h = 0; h < hold; h++) begin
            bus.res_ready = 1'b0;
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 1'($urandom_range(0, 1));
            nout          = 51'({$urandom, $urandom});
            tick();
            check_eq("dn_res_valid", 64'(bus.res_valid), 64'(1));
            check_eq("dn_res_stable", 64'(bus.res_data), 64'(held));
            check_eq("dn_cmd_ready", 64'(bus.cmd_ready), 64'(0));
         end
         // Result handshake and a new command offered in the same cycle.
         bus.res_ready = 1'b1;
         bus.cmd_valid = 1'b1;
         tick();
         bus.res_ready = 1'b0;
         bus.cmd_valid = 1'b0;
         check_eq("hs_res_valid", 64'(bus.res_valid), 64'(0));
         check_eq("hs_busy", 64'(busy), 64'(0));
         check_eq("hs_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      end
      check_eq("cp_no_wdata", 64'(stray), 64'(0));
      bus.wdata_valid = 1'b0;
   endtask

   task automatic reset_model();
      exp_cima    = 1'b0;
      exp_inwidth = 1'b0;
      exp_err     = 1'b0;
      exp_done    = 16'd0;
   endtask

   initial begin
      rstn            = 1'b0;
      st              = 1'b0;
      nout            = '0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_op      = 1'b0;
      bus.cmd_bank    = 1'b0;
      bus.cmd_inwidth = 1'b0;
      bus.wdata_valid = 1'b0;
      bus.wdata       = '0;
      bus.res_ready   = 1'b0;
      reset_model();
      #12;
      rstn = 1'b1;
      #1;
      check_eq("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check_eq("rst_outs", 64'({WA, cima, inwidth, acm_en, busy, err, bus.wdata_ready,
                                bus.res_valid}), 64'(0));
      check_eq("rst_d", 64'(D), 64'(0));
      check_eq("rst_res_data", 64'(bus.res_data), 64'(0));
      check_eq("rst_done_cnt", 64'(done_cnt), 64'(0));
      tick();

      do_wload(1'b1, 0, 1'b0, 1'b1);
      do_wload(1'b0, 2, 1'b0, 1'b0);
      do_wload(1'($urandom_range(0, 1)), 0, 1'b1, 1'b0);

      do_compute(1'b0, 1'b0, 3, 0, 1'b1);
      do_compute(1'b1, 1'b1, int'($urandom_range(0, 6)), 5, 1'b0);
      do_compute(1'b0, 1'b1, -1, 0, 1'b0);
      do_compute(1'b0, 1'b0, int'($urandom_range(0, 6)), 1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_wload(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0);
         end else begin
            do_compute(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 10)),
                       int'($urandom_range(0, 4)), 1'b0);
         end
      end

      // Abort in the middle of RUN, phase 5.
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = 1'b1;
      bus.cmd_bank    = 1'b1;
      bus.cmd_inwidth = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      st            = 1'b1;
      tick();
      st = 1'b0;
      for (int p = 0; p < 5; p++) tick();
      check_eq("ar_pre_acm", 64'(acm_en), 64'(1));
      #2;
      rstn = 1'b0;
      #1;
      check_eq("ar_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check_eq("ar_outs", 64'({WA, cima, inwidth, acm_en, busy, err, bus.wdata_ready,
                               bus.res_valid}), 64'(0));
      check_eq("ar_d", 64'(D), 64'(0));
      check_eq("ar_res_data", 64'(bus.res_data), 64'(0));
      check_eq("ar_done_cnt", 64'(done_cnt), 64'(0));
      reset_model();
      @(posedge clk);
      @(posedge clk);
      #3;
      rstn = 1'b1;
      tick();
      check_eq("ar_post_ready", 64'(bus.cmd_ready), 64'(1));
      check_eq("ar_post_done", 64'(done_cnt), 64'(0));
      check_eq("ar_post_busy", 64'(busy), 64'(0));
      do_compute(1'b0, 1'b1, 2, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
